joy_autoread: RTL and testbench
===============================

JOY_AUTOREAD -- requirements
Module: joy_autoread

Interface
REQ-001 SHALL have parameter HALF, default 4, giving the half-period of the serial clock in clk_sys cycles; legal range is 1..255.
REQ-002 SHALL have port clk_sys  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request for one auto-read frame; sampled each cycle.
REQ-005 SHALL have port port1_di  input  2  controller-port-1 serial data lines; low means pressed.
REQ-006 SHALL have port port2_di  input  2  controller-port-2 serial data lines; low means pressed.
REQ-007 SHALL have port joy_strb  output  1  latch strobe to both ports; active-high.
REQ-008 SHALL have port joy1_clk  output  1  port-1 serial clock; idles high.
REQ-009 SHALL have port joy2_clk  output  1  port-2 serial clock; idles high.
REQ-010 SHALL have port busy  output  1  high while a frame is in progress.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have ports joy1_data, joy2_data, joy3_data, joy4_data  output  16 each  last completed read; 1 means pressed.
- joy1_data is sourced from port1_di[0].
- joy3_data is sourced from port1_di[1].
- joy2_data is sourced from port2_di[0].
- joy4_data is sourced from port2_di[1].

Function
REQ-013 SHALL implement the states IDLE, LATCH, SETTLE, SAMPLE, CLKLO, CLKHI and DONE.
REQ-014 SHALL, in IDLE with start=1, enter LATCH on the next edge; start is ignored in every other state.
REQ-015 SHALL hold joy_strb=1 for exactly 2*HALF cycles in LATCH and 0 in every other state.
REQ-016 SHALL spend exactly HALF cycles in SETTLE with strobe low and clocks high.
REQ-017 SHALL spend exactly one cycle in SAMPLE.
- All four shift registers shift left once, taking the inverted data line: sh <= {sh[14:0], ~di}.
- The first sampled bit therefore ends in bit 15.
REQ-018 SHALL spend HALF cycles in CLKLO with joy1_clk=joy2_clk=0.
REQ-019 SHALL spend HALF cycles in CLKHI with both clocks at 1.
- Then go to SAMPLE if fewer than 16 samples have been taken.
- Otherwise go to DONE.
REQ-020 SHALL, in DONE, copy all four shift registers to joyN_data simultaneously, assert done=1 for that single cycle, and return to IDLE.
REQ-021 SHALL keep joyN_data unchanged from DONE to the next DONE; partial results are never visible.
REQ-022 SHALL drive busy=1 in every state except IDLE; busy and done are registered outputs.
REQ-023 SHALL keep the total frame length at 3*HALF + 16*(2*HALF+1) + 1 cycles of busy=1 (157 cycles for HALF=4).
REQ-024 SHALL issue exactly 16 falling edges on each clock per frame; both clocks are always identical.
REQ-025 SHALL use a 4-bit sample counter and an 8-bit phase counter, with no wrap artefacts at HALF=255.
REQ-026 SHALL allow back-to-back frames: start=1 in the cycle after DONE begins a new LATCH.

Reset
REQ-027 SHALL, while reset=0 at a clock edge, force the following regardless of state, including mid-frame:
- state IDLE;
- joy_strb=0;
- joy1_clk=1, joy2_clk=1;
- busy=0, done=0;
- all shift registers, counters and joyN_data = 16'h0000.
REQ-028 SHALL give reset priority over start in the same cycle.
REQ-029 SHALL make a start after reset is released begin a clean frame, with no carry-over of partial shift data.

Verification
REQ-030 Idle check, HALF=4, start=0 for 100 cycles -> joy_strb=0, clocks=1, busy=0, done=0, all data 0.
REQ-031 Single frame, HALF=4, port1_di[0] model presents 16'h8001 as pressed (line low for bits 15 and 0), all other lines high -> after 157 busy cycles, done pulses once, joy1_data=16'h8001, joy2/3/4_data=0, 16 clock falls are counted, strobe width is 8 cycles.
REQ-032 All lines low for the whole frame -> all four joyN_data=16'hFFFF; a second frame with all lines high -> all 16'h0000, and the values update only in the done cycle.
REQ-033 start re-pulsed at cycle 50 of a frame -> ignored, frame length still 157 cycles, exactly one done.
REQ-034 reset=0 asserted during the 7th CLKLO -> next cycle clocks=1, busy=0, data=0; a later start yields a correct full frame.
REQ-035 HALF=1, back-to-back start held high -> each frame is 52 cycles with one idle cycle between frames, and the strobe is high for 2 cycles.

Source files
------------

// File: rtl/joy_autoread.sv
`default_nettype none
// ============================================================================
// Module   : joy_autoread
// Purpose  : Automatic serial read of two controller ports (four data lines).
//            One strobe, then 16 clock pulses; each line is shifted into a
//            16-bit register and published on completion.
// Revision : 1.0 - initial release
// ============================================================================
module joy_autoread #(
    parameter int HALF = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  port1_di,
    input  logic [1:0]  port2_di,
    output logic        joy_strb,
    output logic        joy1_clk,
    output logic        joy2_clk,
    output logic        busy,
    output logic        done,
    output logic [15:0] joy1_data,
    output logic [15:0] joy2_data,
    output logic [15:0] joy3_data,
    output logic [15:0] joy4_data
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_CLKLO  = 3'd4,
        S_CLKHI  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    // Terminal value of the phase counter; every timed phase lasts HALF cycles.
    localparam logic [7:0] PH_LAST = 8'(HALF - 1);

    state_t      state, state_next;
    logic [7:0]  phase, phase_next;
    logic [3:0]  smp, smp_next;
    logic        latch2, latch2_next;   // second half of the 2*HALF strobe
    logic        phase_end;

    logic        strb_next, clk_next, busy_next, done_next;

    logic [15:0] sh1, sh2, sh3, sh4;

    assign phase_end = (phase == PH_LAST);

    // Next-state logic plus the next values of the registered outputs.
    always_comb begin
        state_next  = state;
        phase_next  = phase + 8'd1;
        smp_next    = smp;
        latch2_next = latch2;
        case (state)
            S_IDLE: begin
                phase_next  = 8'd0;
                smp_next    = 4'd0;
                latch2_next = 1'b0;
                if (start) state_next = S_LATCH;
            end
            S_LATCH: begin
                if (phase_end) begin
                    phase_next = 8'd0;
                    if (latch2) begin
                        latch2_next = 1'b0;
                        state_next  = S_SETTLE;
                    end else begin
                        latch2_next = 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                if (phase_end) begin
                    phase_next = 8'd0;
                    state_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                phase_next = 8'd0;
                state_next = S_CLKLO;
            end
            S_CLKLO: begin
                if (phase_end) begin
                    phase_next = 8'd0;
                    state_next = S_CLKHI;
                end
            end
            S_CLKHI: begin
                if (phase_end) begin
                    phase_next = 8'd0;
                    // smp holds the index of the sample just taken
                    if (smp == 4'd15) begin
                        smp_next   = 4'd0;
                        state_next = S_DONE;
                    end else begin
                        smp_next   = smp + 4'd1;
                        state_next = S_SAMPLE;
                    end
                end
            end
            S_DONE: begin
                phase_next = 8'd0;
                state_next = S_IDLE;
            end
            default: begin
                phase_next = 8'd0;
                state_next = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they track the state exactly.
        strb_next = (state_next == S_LATCH);
        clk_next  = (state_next != S_CLKLO);
        busy_next = (state_next != S_IDLE);
        done_next = (state_next == S_DONE);
    end

    // State, counters and registered control outputs.
    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            state    <= S_IDLE;
            phase    <= 8'd0;
            smp      <= 4'd0;
            latch2   <= 1'b0;
            joy_strb <= 1'b0;
            joy1_clk <= 1'b1;
            joy2_clk <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            phase    <= phase_next;
            smp      <= smp_next;
            latch2   <= latch2_next;
            joy_strb <= strb_next;
            joy1_clk <= clk_next;
            joy2_clk <= clk_next;
            busy     <= busy_next;
            done     <= done_next;
        end
    end

    // Shift registers: cleared at frame start, one inverted bit per SAMPLE cycle.
    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            sh1 <= 16'h0000;
            sh2 <= 16'h0000;
            sh3 <= 16'h0000;
            sh4 <= 16'h0000;
        end else if (state == S_IDLE && start) begin
            sh1 <= 16'h0000;
            sh2 <= 16'h0000;
            sh3 <= 16'h0000;
            sh4 <= 16'h0000;
        end else if (state == S_SAMPLE) begin
            sh1 <= {sh1[14:0], ~port1_di[0]};
            sh2 <= {sh2[14:0], ~port2_di[0]};
            sh3 <= {sh3[14:0], ~port1_di[1]};
            sh4 <= {sh4[14:0], ~port2_di[1]};
        end
    end

    // Published results load on entry to DONE, so they change together with done.
    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            joy1_data <= 16'h0000;
            joy2_data <= 16'h0000;
            joy3_data <= 16'h0000;
            joy4_data <= 16'h0000;
        end else if (state_next == S_DONE) begin
            joy1_data <= sh1;
            joy2_data <= sh2;
            joy3_data <= sh3;
            joy4_data <= sh4;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_joy_autoread.sv
`default_nettype none
// ============================================================================
// Module   : tb_joy_autoread
// Purpose  : Self-checking bench for joy_autoread (HALF=4 and HALF=1 copies).
// Revision : 1.0 - initial release
// ============================================================================
module tb_joy_autoread;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b0;
    logic        start   = 1'b0;
    logic        start_b = 1'b0;
    logic [1:0]  p1 = 2'b11, p2 = 2'b11;
    logic        strb, jc1, jc2, bsy, dn;
    logic [15:0] d1, d2, d3, d4;
    logic        strb_b, jc1_b, jc2_b, bsy_b, dn_b;
    logic [15:0] d1_b, d2_b, d3_b, d4_b;

    int total = 0;
    int bad   = 0;

    // Controller model: button words (1 = pressed) indexed joy1..joy4.
    logic [15:0] pat [4];
    int          idx = 16;
    logic        prev_clk = 1'b1;

    typedef struct {
        logic [15:0] p [4];
        logic [15:0] e [4];
        int          repulse;
    } vec_t;

    always #5 clk_sys = ~clk_sys;

    joy_autoread #(.HALF(4)) u_dut (
        .clk_sys(clk_sys), .reset(reset), .start(start),
        .port1_di(p1), .port2_di(p2),
        .joy_strb(strb), .joy1_clk(jc1), .joy2_clk(jc2),
        .busy(bsy), .done(dn),
        .joy1_data(d1), .joy2_data(d2), .joy3_data(d3), .joy4_data(d4)
    );

    // HALF=1 copy with every line held low (all buttons pressed).
    joy_autoread #(.HALF(1)) u_dut_fast (
        .clk_sys(clk_sys), .reset(reset), .start(start_b),
        .port1_di(2'b00), .port2_di(2'b00),
        .joy_strb(strb_b), .joy1_clk(jc1_b), .joy2_clk(jc2_b),
        .busy(bsy_b), .done(dn_b),
        .joy1_data(d1_b), .joy2_data(d2_b), .joy3_data(d3_b), .joy4_data(d4_b)
    );

    // Serial controller: strobe reloads, each rising port clock advances one bit.
    always @(negedge clk_sys) begin
        logic [3:0] bi;
        if (strb) idx = 0;
        else if (jc1 && !prev_clk && idx < 16) idx = idx + 1;
        prev_clk = jc1;
        if (idx < 16) begin
            bi = 4'(15 - idx);
            p1 = {~pat[2][bi], ~pat[0][bi]};
            p2 = {~pat[3][bi], ~pat[1][bi]};
        end else begin
            p1 = 2'b11;
            p2 = 2'b11;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One HALF=4 frame with full protocol checks; repulse>0 re-pulses start at that busy cycle.
    task automatic run_frame(input vec_t v);
        int          busy_cnt = 0, strb_cnt = 0, falls = 0, dones = 0;
        int          early = 0, clk_diff = 0, cyc;
        logic        pc = 1'b1;
        logic [15:0] snap [4];
        logic [15:0] got  [4];
        bit          ended = 0;
        for (int k = 0; k < 4; k++) pat[k] = v.p[k];
        snap[0] = d1; snap[1] = d2; snap[2] = d3; snap[3] = d4;
        got = snap;
        @(negedge clk_sys);
        start = 1'b1;
        for (cyc = 0; cyc < 400 && !ended; cyc++) begin
            @(negedge clk_sys);
            start = 1'b0;
            if (bsy) busy_cnt++;
            if (strb) strb_cnt++;
            if (pc && !jc1) falls++;
            pc = jc1;
            if (jc1 !== jc2) clk_diff++;
            if (dn) begin
                dones++;
                got[0] = d1; got[1] = d2; got[2] = d3; got[3] = d4;
                snap = got;
            end else if (d1 !== snap[0] || d2 !== snap[1] || d3 !== snap[2] || d4 !== snap[3]) begin
                early++;
            end
            if (v.repulse > 0 && busy_cnt == v.repulse && bsy) start = 1'b1;
            if (!bsy && busy_cnt > 0) ended = 1;
        end
        check("frame_ended", 32'(ended), 32'd1);
        check("busy_len", busy_cnt, 157);
        check("strb_width", strb_cnt, 8);
        check("clk_falls", falls, 16);
        check("done_count", dones, 1);
        check("data_only_at_done", early, 0);
        check("clks_equal", clk_diff, 0);
        check("joy1_data", got[0], v.e[0]);
        check("joy2_data", got[1], v.e[1]);
        check("joy3_data", got[2], v.e[2]);
        check("joy4_data", got[3], v.e[3]);
    endtask

    initial begin
        vec_t tbl [4];
        vec_t rv;
        int   viol;
        bit   reached;

        for (int k = 0; k < 4; k++) pat[k] = 16'h0000;
        tbl[0].p = '{16'h8001, 16'h0000, 16'h0000, 16'h0000};
        tbl[0].e = '{16'h8001, 16'h0000, 16'h0000, 16'h0000}; tbl[0].repulse = 0;
        tbl[1].p = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        tbl[1].e = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}; tbl[1].repulse = 0;
        tbl[2].p = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[2].e = '{16'h0000, 16'h0000, 16'h0000, 16'h0000}; tbl[2].repulse = 0;
        tbl[3].p = '{16'hA5C3, 16'h1234, 16'hFEDC, 16'h0F0F};
        tbl[3].e = '{16'hA5C3, 16'h1234, 16'hFEDC, 16'h0F0F}; tbl[3].repulse = 50;

        // Reset state
        repeat (3) @(negedge clk_sys);
        check("rst_strb", 32'(strb), 32'd0);
        check("rst_clks", {30'd0, jc1, jc2}, 32'd3);
        check("rst_busy", 32'(bsy), 32'd0);
        check("rst_done", 32'(dn), 32'd0);
        check("rst_data", {d1 | d2, d3 | d4}, 32'd0);
        reset = 1'b1;

        // Idle for 100 cycles with start low
        viol = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk_sys);
            if (strb !== 1'b0 || jc1 !== 1'b1 || jc2 !== 1'b1 || bsy !== 1'b0 || dn !== 1'b0 ||
                d1 !== 16'h0 || d2 !== 16'h0 || d3 !== 16'h0 || d4 !== 16'h0) viol++;
        end
        check("idle_100", viol, 0);

        // Table-driven frames
        for (int t = 0; t < 4; t++) run_frame(tbl[t]);

        // Randomized frames; expected result is the presented button word
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                rv.p[k] = 16'($urandom);
                rv.e[k] = rv.p[k];
            end
            rv.repulse = 0;
            run_frame(rv);
        end

        // Reset during the 7th low clock phase
        rv.p = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        rv.e = rv.p; rv.repulse = 0;
        run_frame(rv);
        @(negedge clk_sys);
        start = 1'b1;
        viol = 0; reached = 0;
        for (int c = 0; c < 300 && !reached; c++) begin
            logic pc0;
            pc0 = jc1;
            @(negedge clk_sys);
            start = 1'b0;
            if (pc0 && !jc1) viol++;
            if (viol == 7) reached = 1;
        end
        check("reach_7th_clklo", 32'(reached), 32'd1);
        reset = 1'b0;
        @(negedge clk_sys);
        reset = 1'b1;
        check("midrst_clks", {30'd0, jc1, jc2}, 32'd3);
        check("midrst_busy", 32'(bsy), 32'd0);
        check("midrst_strb", 32'(strb), 32'd0);
        check("midrst_data", {d1 | d2, d3 | d4}, 32'd0);
        rv.p = '{16'h3C5A, 16'h0001, 16'h8000, 16'h7E7E};
        rv.e = rv.p;
        run_frame(rv);

        // Reset wins over start in the same cycle
        @(negedge clk_sys);
        reset = 1'b0; start = 1'b1;
        @(negedge clk_sys);
        reset = 1'b1; start = 1'b0;
        check("rst_over_start", {30'd0, bsy, strb}, 32'd0);
        @(negedge clk_sys);
        check("rst_over_start_idle", 32'(bsy), 32'd0);

        // HALF=1, start held high: frame lengths, gaps and strobe widths
        begin
            int runs[$], gaps[$], strbs[$];
            int cur_b = 0, cur_g = 0, cur_s = 0;
            bit seen = 0;
            start_b = 1'b1;
            for (int c = 0; c < 220; c++) begin
                @(negedge clk_sys);
                if (bsy_b) begin
                    if (seen && cur_g > 0) gaps.push_back(cur_g);
                    cur_g = 0;
                    cur_b++;
                end else begin
                    if (cur_b > 0) begin runs.push_back(cur_b); seen = 1; end
                    cur_b = 0;
                    cur_g++;
                end
                if (strb_b) cur_s++;
                else if (cur_s > 0) begin strbs.push_back(cur_s); cur_s = 0; end
            end
            start_b = 1'b0;
            check("fast_frames", 32'(runs.size() >= 3 && gaps.size() >= 2 && strbs.size() >= 3), 32'd1);
            for (int i = 0; i < 3 && i < runs.size(); i++) check("fast_len", runs[i], 52);
            for (int i = 0; i < 2 && i < gaps.size(); i++) check("fast_gap", gaps[i], 1);
            for (int i = 0; i < 3 && i < strbs.size(); i++) check("fast_strb", strbs[i], 2);
            check("fast_data", {d1_b & d2_b, d3_b & d4_b}, 32'hFFFF_FFFF);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
